alu_issue_ctrl: RTL
===================

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 SHALL have parameters WIDTH, default 8, operand width; C_WIDTH, default 4, command width; DEPTH, default 4, command FIFO entries (power of 2).
REQ-002 SHALL have port CLK, in, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port RST, in, 1: reset, asynchronous and active-low.
REQ-004 SHALL have ports S_VALID in 1 and S_READY out 1: command-side handshake; a transfer occurs on an edge where both are high.
REQ-005 SHALL have ports S_OPA in WIDTH, S_OPB in WIDTH, S_CIN in 1, S_MODE in 1, S_CMD in C_WIDTH and S_INV in 2: the command payload; S_INV is the operand-valid code 01/10/11.
REQ-006 SHALL have ALU-side outputs OPA WIDTH, OPB WIDTH, CIN 1, MODE 1, CMD C_WIDTH, IN_VALID 2 and CE 1: these drive the ALU directly.
REQ-007 SHALL have ALU-side inputs RES WIDTH+1, MUL_RES 2*WIDTH, COUT, OFLOW, G, E, L and ERR, each of the last six 1 bit: the ALU results.
REQ-008 SHALL have ports R_VALID out 1 and R_READY in 1: result-side handshake.
REQ-009 SHALL have ports R_DATA out 2*WIDTH and R_FLAGS out 6: the captured result; R_FLAGS is {ERR,L,E,G,OFLOW,COUT}.

Function
REQ-010 SHALL buffer accepted commands in a DEPTH-entry FIFO; S_READY = not full; pushes while full are impossible by the handshake.
REQ-011 SHALL sequence issue with a state machine of four states: IDLE, ISSUE, WAIT and DONE.
REQ-012 IDLE: SHALL move to ISSUE when the FIFO is non-empty and R_VALID is 0.
REQ-013 ISSUE: one cycle; SHALL pop the head entry, register it onto the ALU-side outputs, load the wait counter, then go to WAIT.
REQ-014 Wait counter load: 3 for multiply commands (MODE=1 and CMD 4'b1001 or 4'b1010); 2 for all other commands.
REQ-015 WAIT: SHALL decrement the counter each cycle; at zero it SHALL capture the result and go to DONE.
REQ-016 Capture, multiply commands: R_DATA = MUL_RES.
REQ-017 Capture, all other commands: R_DATA = RES zero-extended to 2*WIDTH.
REQ-018 Capture: R_FLAGS = ALU flags, sampled on the same edge as R_DATA.
REQ-019 DONE: SHALL hold R_VALID=1 with R_DATA/R_FLAGS stable until the edge where R_READY=1, then go to IDLE with R_VALID=0.
REQ-020 OPA, OPB, CIN, MODE, CMD and IN_VALID SHALL stay constant from ISSUE through capture; the ALU input pipeline requires stable operands.
REQ-021 IN_VALID SHALL be 2'b00 in IDLE and DONE; operand outputs keep their last values.
REQ-022 CE SHALL be 1 whenever RST is high.
REQ-023 Latency: for a command accepted at edge k into an empty FIFO with the FSM in IDLE, R_VALID SHALL be high after edge k+4 (non-multiply) or k+5 (multiply).
REQ-024 A push and a pop in the same cycle SHALL leave the FIFO occupancy unchanged.
REQ-025 At most one command SHALL be in flight; commands SHALL issue in FIFO order.

Reset
REQ-026 RST low SHALL immediately set the FSM to IDLE, empty the FIFO and clear the wait counter.
REQ-027 RST low SHALL immediately force R_VALID=0, R_DATA=0, R_FLAGS=0, S_READY=1.
REQ-028 RST low SHALL immediately force OPA=0, OPB=0, CIN=0, MODE=0, CMD=0, IN_VALID=0, CE=0.
REQ-029 An operation in flight when reset asserts SHALL be discarded; no R_VALID pulse SHALL follow reset release.

Structure
REQ-030 Package alu_pkg SHALL hold WIDTH/C_WIDTH defaults, the multiply command encodings (4'b1001, 4'b1010), the latency constants (2, 3) and the FSM state typedef.
REQ-031 The FIFO SHALL be a sub-module named alu_cmd_fifo, with the same RST, a push/pop interface and full/empty outputs.

Verification
REQ-032 Reset: hold RST low mid-WAIT -> all outputs at reset values, S_READY=1, no R_VALID for 10 cycles after release.
REQ-033 Add: MODE=1 CMD=0 OPA=8'hFF OPB=8'h01 S_INV=11 -> after edge k+4 R_VALID=1, R_DATA=16'h0100, R_FLAGS=6'b000001.
REQ-034 Multiply: MODE=1 CMD=9 OPA=3 OPB=4 S_INV=11 -> after edge k+5 R_DATA=16'h0014 (4*5), R_FLAGS=0.
REQ-035 Backpressure: R_READY=0, offer 6 commands back-to-back -> first reaches DONE, next 4 fill the FIFO, 6th stalls with S_READY=0; releasing R_READY drains all results in order.
REQ-036 Invalid command: MODE=0 CMD=4'b1110 S_INV=11 -> R_DATA=0, R_FLAGS[5] (ERR)=1.
REQ-037 Operand stability: random stream -> scoreboard confirms the ALU-side outputs never change between ISSUE and capture.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants and FSM state type for the ALU issue controller slice.
package alu_pkg;

    localparam int ALU_WIDTH   = 8;
    localparam int ALU_C_WIDTH = 4;

    localparam logic [3:0] CMD_MUL_INC = 4'b1001;
    localparam logic [3:0] CMD_MUL_SHL = 4'b1010;

    // Cycles spent in WAIT before the ALU result is sampled.
    localparam int LAT_ALU = 2;
    localparam int LAT_MUL = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } issue_state_e;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO for the ALU issue controller; head entry is visible combinationally.
module alu_cmd_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head_data,
    output logic          full,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic          do_push;
    logic          do_pop;

    always_comb begin
        empty     = (wr_ptr_q == rd_ptr_q);
        full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_push   = push && !full;
        do_pop    = pop && !empty;
        wr_ptr_d  = wr_ptr_q + (AW+1)'(do_push);
        rd_ptr_d  = rd_ptr_q + (AW+1)'(do_pop);
        head_data = mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Buffers ALU commands, issues them one at a time with stable operands,
// waits the ALU latency and holds the captured result until accepted.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH   = ALU_WIDTH,
    parameter int C_WIDTH = ALU_C_WIDTH,
    parameter int DEPTH   = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 S_VALID,
    output logic                 S_READY,
    input  logic [WIDTH-1:0]     S_OPA,
    input  logic [WIDTH-1:0]     S_OPB,
    input  logic                 S_CIN,
    input  logic                 S_MODE,
    input  logic [C_WIDTH-1:0]   S_CMD,
    input  logic [1:0]           S_INV,
    output logic [WIDTH-1:0]     OPA,
    output logic [WIDTH-1:0]     OPB,
    output logic                 CIN,
    output logic                 MODE,
    output logic [C_WIDTH-1:0]   CMD,
    output logic [1:0]           IN_VALID,
    output logic                 CE,
    input  logic [WIDTH:0]       RES,
    input  logic [2*WIDTH-1:0]   MUL_RES,
    input  logic                 COUT,
    input  logic                 OFLOW,
    input  logic                 G,
    input  logic                 E,
    input  logic                 L,
    input  logic                 ERR,
    output logic                 R_VALID,
    input  logic                 R_READY,
    output logic [2*WIDTH-1:0]   R_DATA,
    output logic [5:0]           R_FLAGS
);

    localparam int PW = 2*WIDTH + 2 + C_WIDTH + 2;

    issue_state_e           state_q, state_d;
    logic [1:0]             cnt_q, cnt_d;
    logic [WIDTH-1:0]       opa_q, opa_d;
    logic [WIDTH-1:0]       opb_q, opb_d;
    logic                   cin_q, cin_d;
    logic                   mode_q, mode_d;
    logic [C_WIDTH-1:0]     cmd_q, cmd_d;
    logic [1:0]             in_valid_q, in_valid_d;
    logic [2*WIDTH-1:0]     r_data_q, r_data_d;
    logic [5:0]             r_flags_q, r_flags_d;

    logic                   fifo_push;
    logic                   fifo_pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [PW-1:0]          push_data;
    logic [PW-1:0]          head_data;
    logic [WIDTH-1:0]       head_opa;
    logic [WIDTH-1:0]       head_opb;
    logic                   head_cin;
    logic                   head_mode;
    logic [C_WIDTH-1:0]     head_cmd;
    logic [1:0]             head_inv;

    function automatic logic is_mul(input logic mode, input logic [C_WIDTH-1:0] cmd);
        return mode && ((cmd == C_WIDTH'(CMD_MUL_INC)) || (cmd == C_WIDTH'(CMD_MUL_SHL)));
    endfunction

    assign fifo_push = S_VALID && !fifo_full;
    assign push_data = {S_OPA, S_OPB, S_CIN, S_MODE, S_CMD, S_INV};
    assign {head_opa, head_opb, head_cin, head_mode, head_cmd, head_inv} = head_data;

    alu_cmd_fifo #(
        .DW    (PW),
        .DEPTH (DEPTH)
    ) u_cmd_fifo (
        .CLK       (CLK),
        .RST       (RST),
        .push      (fifo_push),
        .push_data (push_data),
        .pop       (fifo_pop),
        .head_data (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        cin_d      = cin_q;
        mode_d     = mode_q;
        cmd_d      = cmd_q;
        in_valid_d = in_valid_q;
        r_data_d   = r_data_q;
        r_flags_d  = r_flags_q;
        fifo_pop   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                fifo_pop   = 1'b1;
                opa_d      = head_opa;
                opb_d      = head_opb;
                cin_d      = head_cin;
                mode_d     = head_mode;
                cmd_d      = head_cmd;
                in_valid_d = head_inv;
                cnt_d      = is_mul(head_mode, head_cmd) ? 2'(LAT_MUL) : 2'(LAT_ALU);
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 2'd1;
                // Capture on the edge where the counter reaches zero; operands stay put until then.
                if (cnt_q <= 2'd1) begin
                    cnt_d      = '0;
                    in_valid_d = '0;
                    r_data_d   = is_mul(mode_q, cmd_q) ? MUL_RES : (2*WIDTH)'(RES);
                    r_flags_d  = {ERR, L, E, G, OFLOW, COUT};
                    state_d    = ST_DONE;
                end
            end
            ST_DONE: begin
                if (R_READY) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            opa_q      <= '0;
            opb_q      <= '0;
            cin_q      <= 1'b0;
            mode_q     <= 1'b0;
            cmd_q      <= '0;
            in_valid_q <= '0;
            r_data_q   <= '0;
            r_flags_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            cin_q      <= cin_d;
            mode_q     <= mode_d;
            cmd_q      <= cmd_d;
            in_valid_q <= in_valid_d;
            r_data_q   <= r_data_d;
            r_flags_q  <= r_flags_d;
        end
    end

    assign S_READY  = !fifo_full;
    assign OPA      = opa_q;
    assign OPB      = opb_q;
    assign CIN      = cin_q;
    assign MODE     = mode_q;
    assign CMD      = cmd_q;
    assign IN_VALID = in_valid_q;
    assign CE       = RST;
    assign R_VALID  = (state_q == ST_DONE);
    assign R_DATA   = r_data_q;
    assign R_FLAGS  = r_flags_q;

endmodule
